// File: rtl/des_result_collector.sv
// Result collector behind the pipelined DES core: tags each block with its run index,
// buffers it in a small registered-output FIFO and tracks target matches and drops.
module des_result_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic [1:64]      target,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             in_valid,
  input  logic [1:64]      in_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [1:64]      o_data,
  output logic [CNT_W-1:0] o_index,
  output logic             busy,
  output logic             done,
  output logic             match_found,
  output logic [CNT_W-1:0] match_index,
  output logic             overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_r, state_next_s;
  logic [CNT_W-1:0] count_r, num_r, match_index_r;
  logic [1:64]      target_r;
  logic             match_found_r, overflow_r, busy_r, done_r;
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_next_s, rd_next_s;
  logic [OCC_W-1:0] occ_r, occ_next_s;
  logic             o_valid_r;
  logic [1:64]      o_data_r, head_data_s;
  logic [CNT_W-1:0] o_index_r, head_idx_s;
  logic [1:64]      mem_data_r [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_idx_r  [FIFO_DEPTH];

  logic accept_s, pop_s, push_s, full_s, last_s, hit_s;

  assign accept_s = (state_r == ST_RUN) && in_valid && !arm;
  assign pop_s    = o_valid_r && o_ready && !arm;
  assign full_s   = (occ_r == DEPTH_C);
  assign push_s   = accept_s && (!full_s || pop_s);
  assign last_s   = (count_r == (num_r - CNT_ONE));
  assign hit_s    = accept_s && (in_data == target_r) && !match_found_r;

  // Next-state decode for the run control FSM
  always_comb begin
    state_next_s = state_r;
    if (arm) begin
      state_next_s = (num_blocks == '0) ? ST_DONE : ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = ST_IDLE;
        ST_RUN:  state_next_s = (accept_s && last_s) ? ST_DONE : ST_RUN;
        ST_DONE: state_next_s = ST_DONE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // FIFO pointer/occupancy update; arm flushes everything
  always_comb begin
    wr_next_s  = wr_ptr_r;
    rd_next_s  = rd_ptr_r;
    occ_next_s = occ_r;
    if (arm) begin
      wr_next_s  = '0;
      rd_next_s  = '0;
      occ_next_s = '0;
    end else begin
      wr_next_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_next_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      if (push_s && !pop_s) begin
        occ_next_s = occ_r + OCC_ONE;
      end else if (pop_s && !push_s) begin
        occ_next_s = occ_r - OCC_ONE;
      end else begin
        occ_next_s = occ_r;
      end
    end
  end

  // Next head entry: the block being written lands at the head only when it becomes the sole entry
  always_comb begin
    head_data_s = mem_data_r[rd_next_s];
    head_idx_s  = mem_idx_r[rd_next_s];
    if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_data_s = in_data;
      head_idx_s  = count_r;
    end else begin
      head_data_s = mem_data_r[rd_next_s];
      head_idx_s  = mem_idx_r[rd_next_s];
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r] <= in_data;
      mem_idx_r[wr_ptr_r]  <= count_r;
    end
  end

  // Control, status and registered FIFO head
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r       <= ST_IDLE;
      count_r       <= '0;
      num_r         <= '0;
      target_r      <= '0;
      match_found_r <= 1'b0;
      match_index_r <= '0;
      overflow_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      occ_r         <= '0;
      o_valid_r     <= 1'b0;
      o_data_r      <= '0;
      o_index_r     <= '0;
    end else begin
      state_r   <= state_next_s;
      busy_r    <= (state_next_s == ST_RUN);
      done_r    <= (state_next_s == ST_DONE);
      wr_ptr_r  <= wr_next_s;
      rd_ptr_r  <= rd_next_s;
      occ_r     <= occ_next_s;
      o_valid_r <= (occ_next_s != '0);
      o_data_r  <= (occ_next_s != '0) ? head_data_s : '0;
      o_index_r <= (occ_next_s != '0) ? head_idx_s  : '0;
      if (arm) begin
        target_r      <= target;
        num_r         <= num_blocks;
        count_r       <= '0;
        match_found_r <= 1'b0;
        match_index_r <= '0;
        overflow_r    <= 1'b0;
      end else if (accept_s) begin
        count_r <= count_r + CNT_ONE;
        if (!push_s) begin
          overflow_r <= 1'b1;
        end
        if (hit_s) begin
          match_found_r <= 1'b1;
          match_index_r <= count_r;
        end
      end
    end
  end

  assign o_valid     = o_valid_r;
  assign o_data      = o_data_r;
  assign o_index     = o_index_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign match_found = match_found_r;
  assign match_index = match_index_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_des_result_collector.sv
// Bench for des_result_collector: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_des_result_collector;

  localparam int D  = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          arm = 1'b0;
  logic [1:64]   target = '0;
  logic [CW-1:0] num_blocks = '0;
  logic          in_valid = 1'b0;
  logic [1:64]   in_data = '0;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [1:64]   o_data;
  logic [CW-1:0] o_index;
  logic          busy, done, match_found, overflow;
  logic [CW-1:0] match_index;

  always #5 clk = ~clk;

  des_result_collector #(.FIFO_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .target(target), .num_blocks(num_blocks),
    .in_valid(in_valid), .in_data(in_data), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_index(o_index), .busy(busy), .done(done),
    .match_found(match_found), .match_index(match_index), .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: run phase, counters, flags and the buffered blocks as a queue
  typedef struct {
    logic [63:0]   d;
    logic [CW-1:0] i;
  } ent_t;

  ent_t          m_q[$];
  int            m_phase = 0;   // 0 idle, 1 running, 2 finished
  logic [CW-1:0] m_count = '0;
  logic [CW-1:0] m_num = '0;
  logic [63:0]   m_target = '0;
  bit            m_match = 1'b0;
  logic [CW-1:0] m_midx = '0;
  bit            m_ovf = 1'b0;
  bit            chk_en = 1'b0;

  task automatic model_step();
    ent_t e;
    if (rst_n) begin
      m_q.delete();
      m_phase = 0; m_count = '0; m_num = '0; m_target = '0;
      m_match = 1'b0; m_midx = '0; m_ovf = 1'b0;
    end else if (arm) begin
      m_q.delete();
      m_count = '0; m_match = 1'b0; m_midx = '0; m_ovf = 1'b0;
      m_target = target; m_num = num_blocks;
      m_phase = (num_blocks == 0) ? 2 : 1;
    end else begin
      if (m_q.size() > 0 && o_ready) void'(m_q.pop_front());
      if (m_phase == 1 && in_valid) begin
        if (m_q.size() < D) begin
          e.d = in_data; e.i = m_count;
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
        if (!m_match && in_data == m_target) begin
          m_match = 1'b1; m_midx = m_count;
        end
        if (m_count + 1 == m_num) m_phase = 2;
        m_count = m_count + 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_arm(input logic [63:0] tgt, input logic [CW-1:0] n);
    arm = 1'b1; target = tgt; num_blocks = n; in_valid = 1'b0;
    cycle();
    arm = 1'b0;
  endtask

  task automatic blk(input logic [63:0] d);
    in_valid = 1'b1; in_data = d;
    cycle();
    in_valid = 1'b0;
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_valid", o_valid, (m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("o_data", o_data, m_q[0].d);
        chk("o_index", o_index, m_q[0].i);
      end
      chk("busy", busy, (m_phase == 1));
      chk("done", done, (m_phase == 2));
      chk("match_found", match_found, m_match);
      chk("match_index", match_index, m_midx);
      chk("overflow", overflow, m_ovf);
    end
  end

  localparam logic [63:0] T1 = 64'h85E813540F0AB405;
  localparam logic [63:0] T4 = 64'hDEADBEEF01234567;

  initial begin
    // reset
    rst_n = 1'b1;
    cycle();
    chk_en = 1'b1;
    cycle();
    rst_n = 1'b0;
    chk("rst_o_valid", o_valid, 64'd0);
    chk("rst_o_data", o_data, 64'd0);
    chk("rst_o_index", o_index, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_done", done, 64'd0);
    chk("rst_match_found", match_found, 64'd0);
    chk("rst_match_index", match_index, 64'd0);
    chk("rst_overflow", overflow, 64'd0);

    // basic run with a match at index 1
    o_ready = 1'b1;
    do_arm(T1, 32'd3);
    chk("t1_busy", busy, 64'd1);
    blk(64'h1111111111111111);
    chk("t1_idx0", o_index, 64'd0);
    blk(T1);
    chk("t1_idx1", o_index, 64'd1);
    chk("t1_match", match_found, 64'd1);
    chk("t1_midx", match_index, 64'd1);
    blk(64'h2222222222222222);
    chk("t1_idx2", o_index, 64'd2);
    chk("t1_done", done, 64'd1);
    chk("t1_busy_off", busy, 64'd0);
    chk("t1_ovf", overflow, 64'd0);
    cycle();
    chk("t1_empty", o_valid, 64'd0);

    // overflow with a stalled consumer, then drain
    o_ready = 1'b0;
    do_arm(T1, 32'd6);
    for (int k = 0; k < 6; k++) blk(64'hA000000000000000 + 64'(k));
    chk("t2_ovf", overflow, 64'd1);
    chk("t2_done", done, 64'd1);
    chk("t2_head", o_index, 64'd0);
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_drain_valid", o_valid, 64'd1);
      chk("t2_drain_idx", o_index, 64'(k));
      cycle();
    end
    chk("t2_drained", o_valid, 64'd0);

    // full FIFO with simultaneous pop and push
    o_ready = 1'b0;
    do_arm(T1, 32'd8);
    for (int k = 0; k < 4; k++) blk(64'hB000000000000000 + 64'(k));
    o_ready = 1'b1;
    blk(64'hB000000000000004);
    o_ready = 1'b0;
    chk("t3_no_ovf", overflow, 64'd0);
    chk("t3_head", o_index, 64'd1);
    blk(64'hB000000000000005);
    chk("t3_still_full", overflow, 64'd1);
    o_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("t3_drain_idx", o_index, 64'(k));
      cycle();
    end
    chk("t3_drained", o_valid, 64'd0);

    // first match wins
    do_arm(T4, 32'd8);
    for (int k = 0; k < 8; k++) begin
      blk((k == 2 || k == 5) ? T4 : (64'h1000 + 64'(k)));
      if (k == 2) chk("t4_midx_first", match_index, 64'd2);
    end
    chk("t4_midx", match_index, 64'd2);
    chk("t4_match", match_found, 64'd1);
    chk("t4_done", done, 64'd1);
    cycle();

    // re-arm mid-run, then a zero-length run
    o_ready = 1'b0;
    do_arm(T1, 32'd8);
    blk(64'h3333333333333333);
    blk(T1);
    chk("t5_match_pre", match_found, 64'd1);
    arm = 1'b1; num_blocks = 32'd1; target = T1;
    in_valid = 1'b1; in_data = T1;
    cycle();
    arm = 1'b0; in_valid = 1'b0;
    chk("t5_flushed", o_valid, 64'd0);
    chk("t5_busy", busy, 64'd1);
    chk("t5_match_clr", match_found, 64'd0);
    blk(64'h4444444444444444);
    chk("t5_idx0", o_index, 64'd0);
    chk("t5_done", done, 64'd1);
    o_ready = 1'b1;
    cycle();
    do_arm(T1, 32'd0);
    chk("t5_zero_done", done, 64'd1);
    chk("t5_zero_busy", busy, 64'd0);
    cycle();

    // reset mid-run
    o_ready = 1'b0;
    do_arm(T4, 32'd8);
    blk(T4);
    blk(64'h5555555555555555);
    rst_n = 1'b1;
    cycle();
    rst_n = 1'b0;
    chk("t6_o_valid", o_valid, 64'd0);
    chk("t6_o_data", o_data, 64'd0);
    chk("t6_busy", busy, 64'd0);
    chk("t6_match", match_found, 64'd0);
    chk("t6_ovf", overflow, 64'd0);
    blk(64'h0);
    blk(64'h6666666666666666);
    chk("t6_ignored", o_valid, 64'd0);
    chk("t6_idle_done", done, 64'd0);
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_result_collector.md
Name: des_result_collector

Overview:
- Sits directly downstream of the 16-round pipelined DES encryption core.
- Consumes the core's one-cycle output_valid/result stream (64-bit blocks, no backpressure possible) and tags each block with its sequence index since arm.
- Buffers tagged blocks in a small FIFO with a valid/ready output, and compares every block against a target ciphertext for known-plaintext key-search runs.
- Reports the first match index, completion after a programmed block count, and sticky overflow when the FIFO cannot absorb the pipeline rate.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
- CNT_W, 32, width of block counter, num_blocks, o_index, match_index.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset: synchronous, active-high (port name kept per codebase convention; asserted = 1).
- arm  input  1  one-cycle pulse: latch target and num_blocks, clear counters/flags, flush FIFO, start run.
- target  input  [1:64]  expected ciphertext; sampled only when arm=1.
- num_blocks  input  [CNT_W-1:0]  number of blocks in the run; sampled only when arm=1.
- in_valid  input  1  block valid from the encryption core (its output_valid).
- in_data  input  [1:64]  block from the encryption core (its result).
- o_valid  output  1  FIFO head valid.
- o_ready  input  1  consumer accepts head when o_valid & o_ready.
- o_data  output  [1:64]  FIFO head block.
- o_index  output  [CNT_W-1:0]  sequence index of head block.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- match_found  output  1  sticky: a block equal to target was seen this run.
- match_index  output  [CNT_W-1:0]  index of first matching block.
- overflow  output  1  sticky: at least one block was dropped this run.

Behaviour:
- Reset (rst_n=1 at clock edge): state IDLE; FIFO empty; o_valid=0, o_data=0, o_index=0, busy=0, done=0, match_found=0, match_index=0, overflow=0; count=0; target_reg=0.
- FSM states:
  - IDLE -> RUN on arm; goes to DONE instead if num_blocks=0.
  - RUN -> DONE when the accepted block has index num_blocks-1.
  - DONE -> RUN / DONE on arm, with the same num_blocks=0 rule.
  - arm in RUN restarts the run.
- arm cycle: count<=0; match_found, match_index, overflow cleared; FIFO flushed (pointers zeroed, o_valid<=0); any in_valid in the same cycle is ignored.
- RUN, in_valid=1, not arm:
  - Block index = count; count<=count+1.
  - Push {in_data, count} if FIFO not full or a pop happens the same cycle; otherwise drop the block and set overflow<=1. count still increments.
  - If in_data==target_reg and match_found=0: match_found<=1, match_index<=count. Later matches are ignored.
  - Compare and count happen even when the block is dropped.
- in_valid outside RUN: ignored entirely (no count, push or compare).
- FIFO:
  - Registered output, no fall-through. A push into an empty FIFO at edge N gives o_valid=1 after edge N, so data is available 1 cycle after in_valid.
  - Pop on o_valid & o_ready.
  - Simultaneous push+pop: occupancy unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_data/o_index hold steady while o_valid & !o_ready.
  - FIFO drains in every state.
- count does not wrap in practice: the run ends at num_blocks <= 2^CNT_W-1.
- busy/done are registered decodes of state.
- Reset mid-run aborts immediately; everything returns to reset values.

Test Plan:
- Reset then arm, target=64'h85E813540F0AB405, num_blocks=3; three back-to-back in_valid with 64'h1111..., 64'h85E813540F0AB405, 64'h2222..., o_ready=1 -> o_index 0,1,2 in order; match_found=1, match_index=1; done=1 the cycle after 3rd block; overflow=0.
- o_ready=0, FIFO_DEPTH=4, num_blocks=6, six consecutive in_valid -> 4 entries held (indices 0-3), overflow=1, done=1; then o_ready=1 drains exactly indices 0..3.
- FIFO full with o_ready=1 and in_valid same cycle -> push accepted, no overflow, occupancy stays 4.
- Two matching blocks at indices 2 and 5 (num_blocks=8) -> match_index=2, stays 2.
- arm in RUN after 2 blocks with num_blocks=1 -> FIFO flushed, count=0, flags cleared; next block index 0, then DONE; arm with num_blocks=0 -> DONE directly, busy never high.
- rst_n=1 mid-run with FIFO holding 2 entries -> next cycle all outputs zero, o_valid=0, state IDLE; in_valid then ignored.
